// File: rtl/wb_arb2_wdog.sv
// Two-master / one-slave Wishbone arbiter: registered round-robin grant held for CYC and LOCK,
// combinational slave mux, and a watchdog that ends stalled strobes with ERR after TIMEOUT cycles.
module wb_arb2_wdog #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  input  logic            m0_lock_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  input  logic            m1_lock_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  output logic            s_lock_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,
  output logic [1:0]      gnt_o,
  output logic            timeout_o
);

  localparam bit            WD_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] LP_TO = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_last;
  logic [1:0]    r_gnt;
  logic [CW-1:0] r_cnt;

  logic w_g0;
  logic w_g1;
  logic w_stb_raw;
  logic w_term;
  logic w_fire;

  // r_last remembers the most recent owner so a tie goes to the other master.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
            r_state <= G0;
            r_gnt   <= 2'b01;
            r_last  <= 1'b0;
          end else if (m1_cyc_i) begin
            r_state <= G1;
            r_gnt   <= 2'b10;
            r_last  <= 1'b1;
          end
        end
        G0: begin
          if (!m0_cyc_i && !m0_lock_i) begin
            if (m1_cyc_i) begin
              r_state <= G1;
              r_gnt   <= 2'b10;
              r_last  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_gnt   <= 2'b00;
            end
          end
        end
        G1: begin
          if (!m1_cyc_i && !m1_lock_i) begin
            if (m0_cyc_i) begin
              r_state <= G0;
              r_gnt   <= 2'b01;
              r_last  <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_gnt   <= 2'b00;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 2'b00;
        end
      endcase
    end
  end

  assign w_g0 = (r_state == G0);
  assign w_g1 = (r_state == G1);

  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_cyc_o   = 1'b0;
    s_cti_o   = 3'b000;
    s_bte_o   = 2'b00;
    s_lock_o  = 1'b0;
    w_stb_raw = 1'b0;
    if (w_g0) begin
      s_adr_o   = m0_adr_i;
      s_dat_o   = m0_dat_i;
      s_sel_o   = m0_sel_i;
      s_we_o    = m0_we_i;
      s_cyc_o   = m0_cyc_i;
      s_cti_o   = m0_cti_i;
      s_bte_o   = m0_bte_i;
      s_lock_o  = m0_lock_i;
      w_stb_raw = m0_stb_i;
    end else if (w_g1) begin
      s_adr_o   = m1_adr_i;
      s_dat_o   = m1_dat_i;
      s_sel_o   = m1_sel_i;
      s_we_o    = m1_we_i;
      s_cyc_o   = m1_cyc_i;
      s_cti_o   = m1_cti_i;
      s_bte_o   = m1_bte_i;
      s_lock_o  = m1_lock_i;
      w_stb_raw = m1_stb_i;
    end
  end

  // A slave response in the expiry cycle beats the watchdog.
  assign w_term    = s_ack_i | s_err_i | s_rty_i;
  assign w_fire    = WD_EN && s_cyc_o && w_stb_raw && (r_cnt == LP_TO) && !w_term;
  assign s_stb_o   = w_stb_raw & ~w_fire;
  assign timeout_o = w_fire;

  // Grant changes always pass through a cycle with s_cyc_o low, which clears the count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (WD_EN && s_cyc_o && w_stb_raw && !w_term && !w_fire) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = w_g0 & s_ack_i;
  assign m0_err_o = w_g0 & (s_err_i | w_fire);
  assign m0_rty_o = w_g0 & s_rty_i;
  assign m1_ack_o = w_g1 & s_ack_i;
  assign m1_err_o = w_g1 & (s_err_i | w_fire);
  assign m1_rty_o = w_g1 & s_rty_i;
  assign gnt_o    = r_gnt;

endmodule

// File: tb/tb_wb_arb2_wdog.sv
// Bench for wb_arb2_wdog: directed scenarios then random traffic, all checked against a cycle model.
module tb_wb_arb2_wdog;
  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_lock_i, m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_lock_i, m1_ack_o, m1_err_o, m1_rty_o;
  logic [2:0]  m0_cti_i, m1_cti_i, s_cti_o;
  logic [1:0]  m0_bte_i, m1_bte_i, s_bte_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_lock_o, s_ack_i, s_err_i, s_rty_i;
  logic [1:0]  gnt_o;
  logic        timeout_o;

  int n_err, n_chk;
  // Model: owner 0 = idle, 1 = m0, 2 = m1; last = index of most recent owner.
  int mg, mlast, mcnt, mg_n, mlast_n, mcnt_n;

  wb_arb2_wdog #(.AW(32), .DW(32), .TIMEOUT(TO), .CW(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i),
    .m0_bte_i(m0_bte_i), .m0_lock_i(m0_lock_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_rty_o(m0_rty_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i),
    .m1_bte_i(m1_bte_i), .m1_lock_i(m1_lock_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_lock_o(s_lock_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_rty_i(s_rty_i), .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i, m0_cti_i, m0_bte_i, m0_lock_i} = '0;
    {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i, m1_cti_i, m1_bte_i, m1_lock_i} = '0;
    {s_dat_i, s_ack_i, s_err_i, s_rty_i} = '0;
  endtask

  task automatic model_reset();
    mg = 0; mlast = 1; mcnt = 0;
  endtask

  // Called just after an edge: waits to mid-cycle, compares every output, computes next model state.
  task automatic look();
    logic g0, g1, sc, sst, term, fire;
    logic [42:0] ectl;
    #4;
    g0   = (mg == 1);
    g1   = (mg == 2);
    sc   = g0 ? m0_cyc_i : (g1 ? m1_cyc_i : 1'b0);
    sst  = g0 ? m0_stb_i : (g1 ? m1_stb_i : 1'b0);
    term = s_ack_i | s_err_i | s_rty_i;
    fire = (TO > 0) && sc && sst && (mcnt == TO) && !term;
    ectl = g0 ? {m0_we_i, m0_sel_i, m0_cti_i, m0_bte_i, m0_lock_i, m0_dat_i} :
           g1 ? {m1_we_i, m1_sel_i, m1_cti_i, m1_bte_i, m1_lock_i, m1_dat_i} : '0;
    chk("gnt", gnt_o, g0 ? 2'b01 : (g1 ? 2'b10 : 2'b00));
    chk("s_cyc", s_cyc_o, sc);
    chk("s_stb", s_stb_o, sst && !fire);
    chk("s_adr", s_adr_o, g0 ? m0_adr_i : (g1 ? m1_adr_i : 32'h0));
    chk("s_ctl", {s_we_o, s_sel_o, s_cti_o, s_bte_o, s_lock_o, s_dat_o}, ectl);
    chk("resp", {m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o},
        {g0 && s_ack_i, g0 && (s_err_i || fire), g0 && s_rty_i,
         g1 && s_ack_i, g1 && (s_err_i || fire), g1 && s_rty_i});
    chk("timeout", timeout_o, fire);
    chk("rdat", {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
    mg_n = mg;
    mlast_n = mlast;
    if (mg == 0) begin
      if (m0_cyc_i && m1_cyc_i) mg_n = (mlast == 1) ? 1 : 2;
      else if (m0_cyc_i)        mg_n = 1;
      else if (m1_cyc_i)        mg_n = 2;
    end else if (mg == 1) begin
      if (!m0_cyc_i && !m0_lock_i) mg_n = m1_cyc_i ? 2 : 0;
    end else begin
      if (!m1_cyc_i && !m1_lock_i) mg_n = m0_cyc_i ? 1 : 0;
    end
    if (mg_n != mg && mg_n != 0) mlast_n = mg_n - 1;
    mcnt_n = (sc && sst && !term && !fire && TO > 0) ? mcnt + 1 : 0;
  endtask

  task automatic nxt();
    @(posedge clk_i);
    mg = mg_n; mlast = mlast_n; mcnt = mcnt_n;
    #1;
  endtask

  initial begin
    n_err = 0; n_chk = 0;
    clear_inputs();
    rst_n_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    look();
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;

    // Single requester m1 read, slave acks two cycles after strobe
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_0010; m1_sel_i = 4'hf;
    look(); chk("t1_gnt_pre", gnt_o, 2'b00);
    nxt(); look(); chk("t1_gnt", gnt_o, 2'b10); chk("t1_adr", s_adr_o, 32'h10);
    nxt(); look(); chk("t1_noack", m1_ack_o, 1'b0);
    nxt(); s_ack_i = 1; s_dat_i = 32'hCAFE_0001;
    look(); chk("t1_ack", m1_ack_o, 1'b1); chk("t1_dat", m1_dat_o, 32'hCAFE_0001);
    chk("t1_m0_noack", m0_ack_o, 1'b0);
    nxt(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    look();
    nxt(); look(); chk("t1_idle", gnt_o, 2'b00);

    // Simultaneous requests from reset, handoff, round-robin ties
    nxt(); rst_n_i = 0; model_reset();
    @(posedge clk_i); #1; rst_n_i = 1;
    m0_cyc_i = 1; m1_cyc_i = 1;
    look(); nxt(); look(); chk("t2_first_m0", gnt_o, 2'b01);
    nxt(); look();
    nxt(); m0_cyc_i = 0; look(); chk("t2_hold", gnt_o, 2'b01);
    nxt(); look(); chk("t2_handoff", gnt_o, 2'b10);
    nxt(); m1_cyc_i = 0; look();
    nxt(); look(); chk("t2_idle", gnt_o, 2'b00);
    nxt(); m0_cyc_i = 1; m1_cyc_i = 1; look();
    nxt(); look(); chk("t2_rr_m0", gnt_o, 2'b01);
    nxt(); m0_cyc_i = 0; m1_cyc_i = 0; look();
    nxt(); m0_cyc_i = 1; m1_cyc_i = 1; look();
    nxt(); look(); chk("t2_rr_m1", gnt_o, 2'b10);
    nxt(); m0_cyc_i = 0; m1_cyc_i = 0; look();
    nxt();

    // 4-beat burst from m0 with m1 requesting throughout, then lock hold
    m0_cyc_i = 1; m0_stb_i = 1; m0_cti_i = 3'b010; m0_adr_i = 32'h100; m0_sel_i = 4'hf;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h200;
    look(); nxt();
    for (int b = 0; b < 4; b++) begin
      m0_cti_i = (b == 3) ? 3'b111 : 3'b010;
      m0_adr_i = 32'h100 + 32'(4 * b);
      s_ack_i = 1; s_dat_i = $urandom;
      look();
      chk("t3_burst_gnt", gnt_o, 2'b01); chk("t3_burst_ack", m0_ack_o, 1'b1);
      chk("t3_m1_noack", m1_ack_o, 1'b0); chk("t3_cti", s_cti_o, m0_cti_i);
      nxt();
    end
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_cti_i = 0;
    look(); chk("t3_drop_hold", gnt_o, 2'b01);
    nxt(); look(); chk("t3_m1_after", gnt_o, 2'b10);
    nxt(); m1_cyc_i = 0; m1_stb_i = 0; m0_cyc_i = 1; m0_lock_i = 1; look();
    nxt(); m1_cyc_i = 1; look(); chk("t3_lock_gnt", gnt_o, 2'b01);
    nxt(); m0_cyc_i = 0; look(); chk("t3_lock_a", gnt_o, 2'b01);
    nxt(); look(); chk("t3_lock_b", gnt_o, 2'b01);
    nxt(); m0_lock_i = 0; look(); chk("t3_lock_c", gnt_o, 2'b01);
    nxt(); look(); chk("t3_lock_rel", gnt_o, 2'b10);
    nxt(); m1_cyc_i = 0; look();
    nxt();

    // Watchdog: unacked write from m0, then a run acked in the expiry cycle
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_dat_i = 32'h1234_5678; m0_adr_i = 32'h40;
    look(); nxt();
    for (int k = 1; k <= 5; k++) begin
      look();
      chk("t4_err", m0_err_o, k == 5); chk("t4_timeout", timeout_o, k == 5);
      chk("t4_stb", s_stb_o, k != 5); chk("t4_noack", m0_ack_o, 1'b0);
      nxt();
    end
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    look(); nxt();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
    look(); nxt();
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) s_ack_i = 1;
      look();
      if (k == 5) begin
        chk("t4b_ack", m0_ack_o, 1'b1); chk("t4b_noerr", m0_err_o, 1'b0);
        chk("t4b_noto", timeout_o, 1'b0);
      end
      nxt();
    end
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    look(); nxt();

    // Abandon after two stalled strobes, then a fresh full timeout
    m1_cyc_i = 1; m1_stb_i = 1;
    look(); nxt();
    for (int k = 1; k <= 2; k++) begin
      look(); chk("t6_noerr", m1_err_o, 1'b0); nxt();
    end
    m1_cyc_i = 0;
    look();
    chk("t6_scyc", s_cyc_o, 1'b0); chk("t6_err", m1_err_o, 1'b0); chk("t6_to", timeout_o, 1'b0);
    nxt(); m1_stb_i = 0; look(); nxt();
    m1_cyc_i = 1; m1_stb_i = 1;
    look(); nxt();
    for (int k = 1; k <= 5; k++) begin
      look(); chk("t6_refire", timeout_o, k == 5); nxt();
    end
    m1_cyc_i = 0; m1_stb_i = 0;
    look(); nxt();

    // Asynchronous reset while m1 owns the bus
    m1_cyc_i = 1; m1_stb_i = 1;
    look(); nxt(); look(); chk("t5_g1", gnt_o, 2'b10);
    nxt();
    s_ack_i = 1;
    #2; rst_n_i = 0; model_reset();
    #1;
    chk("t5_gnt", gnt_o, 2'b00); chk("t5_scyc", s_cyc_o, 1'b0);
    chk("t5_resp", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, timeout_o}, 5'b0);
    @(posedge clk_i); #1;
    rst_n_i = 1; clear_inputs();
    m0_cyc_i = 1; m1_cyc_i = 1;
    look(); nxt(); look(); chk("t5_tie_m0", gnt_o, 2'b01);
    nxt(); m0_cyc_i = 0; m1_cyc_i = 0; look(); nxt();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      m0_cyc_i  = ($urandom_range(3) != 0);  m1_cyc_i  = ($urandom_range(3) != 0);
      m0_stb_i  = ($urandom_range(7) != 0);  m1_stb_i  = ($urandom_range(7) != 0);
      m0_lock_i = ($urandom_range(7) == 0);  m1_lock_i = ($urandom_range(7) == 0);
      m0_we_i   = 1'($urandom_range(1));     m1_we_i   = 1'($urandom_range(1));
      m0_adr_i  = $urandom; m1_adr_i = $urandom; m0_dat_i = $urandom; m1_dat_i = $urandom;
      m0_sel_i  = 4'($urandom_range(15));    m1_sel_i  = 4'($urandom_range(15));
      m0_cti_i  = 3'($urandom_range(7));     m1_cti_i  = 3'($urandom_range(7));
      m0_bte_i  = 2'($urandom_range(3));     m1_bte_i  = 2'($urandom_range(3));
      s_ack_i   = ($urandom_range(5) == 0);
      s_err_i   = ($urandom_range(15) == 0);
      s_rty_i   = ($urandom_range(15) == 0);
      s_dat_i   = $urandom;
      look();
      nxt();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
